// File: rtl/priority_encoder8to3.sv
// -----------------------------------------------------------------------------
// priority_encoder8to3
//
// Registered 8-to-3 priority encoder with request latching and a valid/ack
// handshake. Events on the eight request lines are captured into a pending
// register. The index of the highest-priority pending request is presented on
// `out` with `valid` high. It is held, and never preempted, until the consumer
// acknowledges it. The acknowledged pending bit is then cleared. The encoded
// index feeds the 3-to-8 decoder tree so it can be turned back into one-hot.
//
// Parameters
//   PRIORITY_HIGH_FIRST : 1 = bit 7 is highest priority, 0 = bit 0 is highest
//   EDGE_DETECT         : 1 = capture rising edges of in[i], 0 = capture levels
//
// Ports
//   clk      in   1  single clock, all state updates on the rising edge
//   reset_n  in   1  synchronous active-low reset, dominates all other inputs
//   in       in   8  request lines, one per index
//   enable   in   1  1 = capture allowed, 0 = new events discarded
//   ack      in   1  consumer acknowledges the presented index
//   out      out  3  encoded index of the presented request
//   valid    out  1  out holds a presented request
//   pending  out  8  latched requests not yet acknowledged
//   overflow out  1  sticky: an event hit a bit that was already pending
// -----------------------------------------------------------------------------
module priority_encoder8to3 #(
    parameter bit PRIORITY_HIGH_FIRST = 1'b1,
    parameter bit EDGE_DETECT         = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in,
    input  logic       enable,
    input  logic       ack,
    output logic [2:0] out,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q,    state_d;
    logic [7:0] pending_q,  pending_d;
    logic [7:0] in_prev_q,  in_prev_d;
    logic [2:0] out_q,      out_d;
    logic       valid_q,    valid_d;
    logic       overflow_q, overflow_d;

    logic [7:0] ev;
    logic [7:0] set;
    logic [7:0] clr;
    logic       grant_done;
    logic [2:0] top_idx;

    // Index of the highest-priority set bit. Scanning in ascending priority
    // order lets the last hit win, so no early exit is needed.
    function automatic logic [2:0] pick_index(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (PRIORITY_HIGH_FIRST) begin
                if (req[i]) idx = 3'(i);
            end else begin
                if (req[7 - i]) idx = 3'(7 - i);
            end
        end
        return idx;
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only; the reset is
    // sampled inside the clocked block, so it is synchronous to clk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pending_q  <= 8'h00;
            in_prev_q  <= 8'h00;
            out_q      <= 3'd0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            in_prev_q  <= in_prev_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Capture datapath: event detection, pending update, sticky overflow
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        ev         = EDGE_DETECT ? (in & ~in_prev_q) : in;
        set        = ev & {8{enable}};
        grant_done = (state_q == PRESENT) && ack;
        clr        = grant_done ? (8'h01 << out_q) : 8'h00;

        // Set is OR-ed in after the clear, so a same-cycle re-arm survives.
        pending_d  = (pending_q & ~clr) | set;
        overflow_d = overflow_q | (|(set & pending_q & ~clr));
        in_prev_d  = in;
        top_idx    = pick_index(pending_q);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pending_q != 8'h00) state_d = PRESENT;
            end
            PRESENT: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: the index is latched only on entry to PRESENT, so later
    // requests (even higher-priority ones) cannot preempt it.
    // -------------------------------------------------------------------------
    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q != 8'h00) begin
                    out_d   = top_idx;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                valid_d = !ack;
            end
            default: valid_d = 1'b0;
        endcase
    end

    assign out      = out_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: doc/priority_encoder8to3.md
Name: priority_encoder8to3

Overview:
- Registered 8-to-3 priority encoder with request latching and a valid/ack handshake; the inverse of the team's 3-to-8 decoder path.
- Captures events on eight request lines into a pending register.
- Presents the index of the highest-priority pending request on a 3-bit bus and holds it until a consumer acknowledges. The acknowledged bit is then cleared.
- Sits in front of the 3-to-8 decoder tree so that an encoded index can be round-tripped back to one-hot.

Parameters:
- PRIORITY_HIGH_FIRST, 1, 1 = bit 7 is highest priority; 0 = bit 0 is highest.
- EDGE_DETECT, 1, 1 = capture rising edges of in[i]; 0 = capture whenever in[i] is high (level).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- in  input  8  request lines, one per index.
- enable  input  1  1 = request capture is allowed; 0 = new events are discarded.
- ack  input  1  consumer acknowledges the presented index.
- out  output  3  encoded index of the presented request.
- valid  output  1  out holds a presented request.
- pending  output  8  latched requests not yet acknowledged.
- overflow  output  1  sticky flag: an event arrived on a bit that was already pending.

Behaviour:
- Interface (decided): one clock; reset is synchronous and active-low.
- Reset: reset_n=0 at a clk edge sets pending=0, out=3'b000, valid=0, overflow=0, in_prev=0 and state=IDLE. Reset dominates enable, ack and in.
- Reset mid-operation: a presented request is dropped with no ack required, and valid is 0 after that edge.
- Event detection:
  - EDGE_DETECT=1: ev[i] = in[i] & ~in_prev[i].
  - EDGE_DETECT=0: ev[i] = in[i].
  - in_prev <= in on every non-reset edge, regardless of enable.
- Capture:
  - set = ev & {8{enable}}.
  - clr = one-hot of out when (state==PRESENT && ack), else 0.
  - pending <= (pending & ~clr) | set.
  - If set and clr hit the same bit in the same cycle, the set wins and the bit stays pending.
- Overflow: overflow <= 1 when (set & pending & ~clr) != 0. It is cleared only by reset.
- State machine (IDLE, PRESENT):
  - IDLE: if pending != 0 (registered value), out <= index of the highest-priority set bit per PRIORITY_HIGH_FIRST, valid <= 1, go to PRESENT. Otherwise out holds its last value and valid=0.
  - PRESENT: out and valid are held stable. Changes on in, and new higher-priority requests, do not preempt.
  - PRESENT with ack=1 at the edge: clear that pending bit, valid <= 0, go to IDLE.
- Latency:
  - Event sampled at edge N: the pending bit is visible after edge N.
  - valid=1 with out is visible after edge N+1 (when IDLE).
  - Minimum of 2 cycles per grant (one IDLE bubble after each ack).
- ack is ignored while valid=0. ack held high continuously results in one grant per 2 cycles.
- enable=0 blocks new captures only. Already-pending requests are still presented and acknowledged.
- Level mode (EDGE_DETECT=0): an in[i] still high when its bit is acked re-arms the bit in the same cycle (set wins). This is expected, and it also raises overflow if the bit was already pending.

Test Plan:
- Reset then idle: reset_n=0 for 2 edges, then in=0 -> out=0, valid=0, pending=8'h00, overflow=0 held for 10 cycles.
- Priority (defaults): pulse in=8'b0010_0100 for 1 cycle -> pending=8'h24. Next edge: out=5, valid=1. After ack, pending=8'h04, valid=0 for 1 cycle, then out=2, valid=1. After a second ack, pending=0.
- Low-first (PRIORITY_HIGH_FIRST=0), same stimulus -> out=2 first, then out=5.
- No preemption / enable gating:
  - While presenting out=2, pulse in[7] -> out stays 2 until ack, then out=7.
  - Repeat with enable=0 during the pulse -> in[7] is never pending.
- Overflow and ack collision (defaults):
  - in[3] rises, falls, and rises again while bit 3 is pending and unacked -> overflow=1 and stays 1.
  - in[3] rises in the same cycle that ack clears bit 3 -> pending[3] remains 1 and overflow stays 0 (on a fresh reset).
- Reset mid-operation: valid=1 with out=6, assert reset_n=0 for 1 edge -> valid=0, pending=0, out=0 with no ack.
